// File: rtl/int_fu_pkg.sv
// Shared definitions for the scoreboard integer functional units: opcodes,
// FSM state encoding and default datapath widths.
package int_fu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_TAG_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } fu_state_t;

endpackage

// File: rtl/int_addsub_fu_slice.sv
// Combinational SLICE_W-bit adder slice with carry in/out.
// With INT_ADDSUB_OVF_EN defined it also exports the carry into its MSB.
module addsub_slice #(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
`ifdef INT_ADDSUB_OVF_EN
    ,
    output logic               c_msb
`endif
);

    logic c_top;

    // Split off the MSB so the carry into it is a real net, not a derived value.
    generate
        if (SLICE_W > 1) begin : g_split
            logic [SLICE_W-1:0] low;
            assign low = {1'b0, a[SLICE_W-2:0]} + {1'b0, b[SLICE_W-2:0]}
                       + {{(SLICE_W-1){1'b0}}, cin};
            assign c_top = low[SLICE_W-1];
            assign sum[SLICE_W-2:0] = low[SLICE_W-2:0];
        end else begin : g_single
            assign c_top = cin;
        end
    endgenerate

    assign {cout, sum[SLICE_W-1]} = {1'b0, a[SLICE_W-1]} + {1'b0, b[SLICE_W-1]}
                                  + {1'b0, c_top};

`ifdef INT_ADDSUB_OVF_EN
    assign c_msb = c_top;
`endif

endmodule

// File: rtl/int_addsub_fu.sv
// Multi-cycle add/subtract unit: one SLICE_W-bit slice per clock, result held until granted.
// Optional signed-overflow output res_ovf is enabled by defining INT_ADDSUB_OVF_EN.
module int_addsub_fu
    import int_fu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SLICE_W = 4,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic             issue_op,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_cout,
`ifdef INT_ADDSUB_OVF_EN
    output logic             res_ovf,
`endif
    output logic             busy
);

    localparam int NSL = WIDTH / SLICE_W;
    localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

    fu_state_t          state_q;
    logic [KW-1:0]      k_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q, b_q, acc_q, acc_d;
    logic [TAG_W-1:0]   tag_q, res_tag_q;
    logic               op_q;
    logic [WIDTH-1:0]   res_data_q;
    logic               res_cout_q;
    logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
    logic               sl_cout;
`ifdef INT_ADDSUB_OVF_EN
    logic               sl_cmsb;
    logic               res_ovf_q;
`endif

    always_comb begin
        sl_a  = a_q[k_q*SLICE_W +: SLICE_W];
        sl_b  = b_q[k_q*SLICE_W +: SLICE_W];
        acc_d = acc_q;
        acc_d[k_q*SLICE_W +: SLICE_W] = sl_sum;
    end

    addsub_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
`ifdef INT_ADDSUB_OVF_EN
        .c_msb(sl_cmsb),
`endif
        .cout (sl_cout)
    );

    // Operands and partial sum carry no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && issue_valid) begin
            a_q   <= src_a;
            b_q   <= src_b ^ {WIDTH{issue_op}};
            tag_q <= issue_tag;
            op_q  <= issue_op;
        end
        if (state_q == EXEC) begin
            acc_q <= acc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            carry_q    <= 1'b0;
            res_data_q <= '0;
            res_tag_q  <= '0;
            res_cout_q <= 1'b0;
`ifdef INT_ADDSUB_OVF_EN
            res_ovf_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_valid) begin
                        carry_q <= issue_op;
                        k_q     <= '0;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    carry_q <= sl_cout;
                    k_q     <= k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        res_data_q <= acc_d;
                        res_tag_q  <= tag_q;
                        // For SUB the raw carry is "no borrow", so invert it.
                        res_cout_q <= sl_cout ^ op_q;
`ifdef INT_ADDSUB_OVF_EN
                        res_ovf_q  <= sl_cmsb ^ sl_cout;
`endif
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign issue_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign res_data    = res_data_q;
    assign res_tag     = res_tag_q;
    assign res_cout    = res_cout_q;
`ifdef INT_ADDSUB_OVF_EN
    assign res_ovf     = res_ovf_q;
`endif

endmodule

// File: tb/tb_int_addsub_fu.sv
// Directed and randomised self-checking bench for int_addsub_fu (default 16-bit, 4-bit slices).
module tb_int_addsub_fu;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready, issue_op;
    logic [2:0]  issue_tag, res_tag;
    logic [15:0] src_a, src_b, res_data;
    logic        res_valid, res_ready, res_cout, busy;
`ifdef INT_ADDSUB_OVF_EN
    logic        res_ovf;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    int_addsub_fu #(.WIDTH(16), .SLICE_W(4), .TAG_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .issue_op   (issue_op),
        .issue_tag  (issue_tag),
        .src_a      (src_a),
        .src_b      (src_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .res_cout   (res_cout),
`ifdef INT_ADDSUB_OVF_EN
        .res_ovf    (res_ovf),
`endif
        .busy       (busy)
    );

    // Issue one op, expect the result 4 edges later, hold res_ready low for
    // 'hold' cycles while checking stability, then grant write-back.
    task automatic do_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] tag, input logic [15:0] exp_d,
                         input logic exp_c, input int hold, input string nm);
        int w;
        int lat;
        res_ready = 1'b0;
        w = 0;
        while (!issue_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        issue_valid = 1'b1; issue_op = op; src_a = a; src_b = b; issue_tag = tag;
        @(posedge clk); #1;
        issue_valid = 1'b0; src_a = 16'hDEAD; src_b = 16'hBEEF; issue_tag = 3'd0;
        nvec++;
        if (busy !== 1'b1 || issue_ready !== 1'b0) begin
            nerr++; $display("FAIL %s accept: busy=%b issue_ready=%b, want 1/0", nm, busy, issue_ready);
        end
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        nvec++;
        if (lat !== 4) begin
            nerr++; $display("FAIL %s latency: got %0d, want 4", nm, lat);
        end
        nvec++;
        if (res_data !== exp_d || res_cout !== exp_c || res_tag !== tag) begin
            nerr++;
            $display("FAIL %s result: data=%h cout=%b tag=%0d, want %h/%b/%0d",
                     nm, res_data, res_cout, res_tag, exp_d, exp_c, tag);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            nvec++;
            if (res_valid !== 1'b1 || res_data !== exp_d || res_tag !== tag || res_cout !== exp_c) begin
                nerr++;
                $display("FAIL %s hold[%0d]: valid=%b data=%h, want 1/%h", nm, i, res_valid, res_data, exp_d);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        nvec++;
        if (issue_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== exp_d) begin
            nerr++;
            $display("FAIL %s writeback: issue_ready=%b res_valid=%b data=%h, want 1/0/%h",
                     nm, issue_ready, res_valid, res_data, exp_d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; issue_valid = 1'b0; issue_op = 1'b0; issue_tag = 3'd0;
        src_a = 16'd0; src_b = 16'd0; res_ready = 1'b0;
        #2;
        nvec++;
        if (issue_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 ||
            res_data !== 16'd0 || res_tag !== 3'd0 || res_cout !== 1'b0) begin
            nerr++;
            $display("FAIL reset_vals: ready=%b valid=%b busy=%b data=%h tag=%0d cout=%b, want 1/0/0/0/0/0",
                     issue_ready, res_valid, busy, res_data, res_tag, res_cout);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        nvec++;
        if (issue_ready !== 1'b1 || busy !== 1'b0) begin
            nerr++; $display("FAIL reset_release: ready=%b busy=%b, want 1/0", issue_ready, busy);
        end
    endtask

    task automatic test_basic();
        do_op(1'b1, 16'd8, 16'd6, 3'd5, 16'd2, 1'b0, 0, "sub_8_6");
        do_op(1'b0, 16'd3, 16'd4, 3'd1, 16'd7, 1'b0, 0, "add_3_4");
    endtask

    task automatic test_wrap();
        do_op(1'b1, 16'd0, 16'd1, 3'd2, 16'hFFFF, 1'b1, 0, "sub_0_1");
        do_op(1'b0, 16'hFFFF, 16'd1, 3'd3, 16'h0000, 1'b1, 0, "add_ffff_1");
        do_op(1'b1, 16'h1234, 16'h1234, 3'd4, 16'h0000, 1'b0, 0, "sub_equal");
    endtask

    task automatic test_backpressure();
        int lat;
        res_ready = 1'b0;
        issue_valid = 1'b1; issue_op = 1'b0; src_a = 16'd1234; src_b = 16'd4321; issue_tag = 3'd2;
        @(posedge clk); #1;
        // Second op presented continuously; it must wait for the write-back.
        issue_op = 1'b1; src_a = 16'd10; src_b = 16'd3; issue_tag = 3'd6;
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        nvec++;
        if (lat !== 4) begin
            nerr++; $display("FAIL bp_latency: got %0d, want 4", lat);
        end
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (res_valid !== 1'b1 || res_data !== 16'd5555 || res_tag !== 3'd2 || issue_ready !== 1'b0) begin
                nerr++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%0d tag=%0d ready=%b, want 1/5555/2/0",
                         i, res_valid, res_data, res_tag, issue_ready);
            end
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        nvec++;
        if (issue_ready !== 1'b1 || res_valid !== 1'b0) begin
            nerr++; $display("FAIL bp_release: ready=%b valid=%b, want 1/0", issue_ready, res_valid);
        end
        @(posedge clk); #1;
        issue_valid = 1'b0;
        nvec++;
        if (busy !== 1'b1 || res_data !== 16'd5555) begin
            nerr++; $display("FAIL bp_second_accept: busy=%b data=%0d, want 1/5555", busy, res_data);
        end
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        nvec++;
        if (lat !== 4 || res_data !== 16'd7 || res_tag !== 3'd6 || res_cout !== 1'b0) begin
            nerr++;
            $display("FAIL bp_second_result: lat=%0d data=%0d tag=%0d cout=%b, want 4/7/6/0",
                     lat, res_data, res_tag, res_cout);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        bit saw_valid;
        issue_valid = 1'b1; issue_op = 1'b1; src_a = 16'd100; src_b = 16'd7; issue_tag = 3'd1;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        nvec++;
        if (issue_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 ||
            res_data !== 16'd0 || res_tag !== 3'd0 || res_cout !== 1'b0) begin
            nerr++;
            $display("FAIL async_reset: ready=%b valid=%b busy=%b data=%h tag=%0d cout=%b, want 1/0/0/0/0/0",
                     issue_ready, res_valid, busy, res_data, res_tag, res_cout);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        saw_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (res_valid) saw_valid = 1'b1;
        end
        nvec++;
        if (saw_valid !== 1'b0) begin
            nerr++; $display("FAIL async_abandon: res_valid seen=%b, want 0", saw_valid);
        end
        do_op(1'b0, 16'd2, 16'd3, 3'd7, 16'd5, 1'b0, 0, "after_reset_add");
    endtask

`ifdef INT_ADDSUB_OVF_EN
    task automatic test_ovf();
        do_op(1'b0, 16'h7FFF, 16'd1, 3'd1, 16'h8000, 1'b0, 0, "ovf_add");
        nvec++;
        if (res_ovf !== 1'b1) begin
            nerr++; $display("FAIL ovf_add_flag: got %b, want 1", res_ovf);
        end
        do_op(1'b1, 16'h8000, 16'd1, 3'd2, 16'h7FFF, 1'b0, 0, "ovf_sub");
        nvec++;
        if (res_ovf !== 1'b1) begin
            nerr++; $display("FAIL ovf_sub_flag: got %b, want 1", res_ovf);
        end
        do_op(1'b0, 16'd3, 16'd4, 3'd3, 16'd7, 1'b0, 0, "ovf_none");
        nvec++;
        if (res_ovf !== 1'b0) begin
            nerr++; $display("FAIL ovf_none_flag: got %b, want 0", res_ovf);
        end
    endtask
`endif

    task automatic test_random();
        logic        op;
        logic [15:0] a, b;
        logic [2:0]  tag;
        logic [16:0] s;
        for (int n = 0; n < 24; n++) begin
            op  = 1'($urandom_range(0, 1));
            a   = 16'($urandom);
            b   = 16'($urandom);
            tag = 3'($urandom_range(0, 7));
            s   = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
            do_op(op, a, b, tag, s[15:0], s[16], $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_async_reset();
`ifdef INT_ADDSUB_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
